// File: rtl/uart_capture_monitor_pkg.sv
// Package uart_capture_pkg: shared types and helpers for the UART capture monitor.
//   state_t        receive FSM states
//   CLKS_PER_BAUD  clocks per bit for the default 50 MHz / 10 Mbaud configuration
//   HALF_BAUD      clocks from start-bit edge to its middle, default configuration
//   cnt_width()    width of a counter that must hold values 0..n-1
package uart_capture_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEF_CLOCK_FREQ = 50_000_000;
    localparam int DEF_BAUD_RATE  = 10_000_000;
    localparam int CLKS_PER_BAUD  = DEF_CLOCK_FREQ / DEF_BAUD_RATE;
    localparam int HALF_BAUD      = CLKS_PER_BAUD / 2;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_capture_monitor_if.sv
// Read-side handshake between the capture monitor and its consumer.
//   rd_data   head byte of the capture FIFO (zero-extended above DATA_BITS)
//   rd_valid  FIFO non-empty
//   rd_ready  consumer accepts the head byte when rd_valid is also high
// master: the monitor (drives data/valid), slave: the bench/consumer.
interface uart_capture_monitor_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_capture_monitor_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered occupancy.
//   clk, rst     clock, synchronous active-high reset (pointers/count only)
//   push_i       write wr_data_i; accepted when not full, or when full and a pop happens
//   wr_data_i    write data
//   pop_i        remove head; ignored while empty
//   rd_data_o    head entry (meaningful only while !empty_o)
//   empty_o      count == 0
//   full_o       count == DEPTH
//   count_o      occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // succeeds when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_capture_monitor.sv
// uart_capture_monitor: cycle-exact UART receive monitor for system benches.
// Samples serial_in at mid-bit, frames bytes and buffers them in a FWFT FIFO.
// Optional feature macro: UART_CAPTURE_PARITY_EN (adds PARITY state,
// parameter PARITY_ODD and output parity_err).
//   clk, rst    clock, synchronous active-high reset
//   serial_in   asynchronous UART line, idle high
//   rd_if       master modport: rd_data/rd_valid out, rd_ready in
//   count       FIFO occupancy
//   rx_total    good frames since reset (wraps)
//   frame_err   sticky, stop bit sampled low
//   overflow    sticky, good frame dropped because FIFO was full
//   clear_err   pulse clearing sticky flags (a same-cycle new event wins)
//   parity_err  sticky, parity mismatch on a committed frame (feature only)
module uart_capture_monitor
    import uart_capture_pkg::*;
#(
    parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 256
`ifdef UART_CAPTURE_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in,
    uart_capture_monitor_if.master rd_if,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            rx_total,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   clear_err
`ifdef UART_CAPTURE_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int BC_W = cnt_width(CPB);
    localparam int BN_W = cnt_width(DATA_BITS);

    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(CPB - 1);
    localparam logic [BC_W-1:0] HALF_LAST = BC_W'(HALF - 1);
    localparam logic [BN_W-1:0] BN_LAST   = BN_W'(DATA_BITS - 1);

    logic                 sync1_q, rx_s_q;
    state_t               state_q, state_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic [BN_W-1:0]      bn_q, bn_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [31:0]          rx_total_q, rx_total_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;

    logic data_smp, stop_smp, good_frame, ferr_evt, ovf_evt, pop;
    logic fifo_empty, fifo_full;

    // Two-flop synchroniser, preset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rx_s_q  <= sync1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bc_q    <= '0;
            bn_q    <= '0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            bn_q    <= bn_d;
        end
    end

    // FSM next state. STOP returns to IDLE at its mid-bit sample, so the
    // next start edge can be seen without waiting for the stop bit to end.
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q + 1'b1;
        bn_d    = bn_q;
        unique case (state_q)
            IDLE: begin
                bc_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (bc_q == HALF_LAST) begin
                    bc_d    = '0;
                    bn_d    = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bc_q == BC_LAST) begin
                    bc_d = '0;
                    bn_d = bn_q + 1'b1;
                    if (bn_q == BN_LAST) begin
`ifdef UART_CAPTURE_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_CAPTURE_PARITY_EN
            PARITY: begin
                if (bc_q == BC_LAST) begin
                    bc_d    = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bc_q == BC_LAST) begin
                    bc_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                bc_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: sample strobes and frame verdict.
    always_comb begin
        data_smp   = (state_q == DATA) && (bc_q == BC_LAST);
        stop_smp   = (state_q == STOP) && (bc_q == BC_LAST);
        good_frame = stop_smp && rx_s_q;
        ferr_evt   = stop_smp && !rx_s_q;
    end

    always_ff @(posedge clk) begin
        if (data_smp) shift_q[bn_q] <= rx_s_q;
    end

    assign pop = rd_if.rd_valid && rd_if.rd_ready;
    // A full FIFO still accepts the byte when the head is popped in the same cycle.
    assign ovf_evt = good_frame && fifo_full && !pop;

`ifdef UART_CAPTURE_PARITY_EN
    logic par_bit_q;
    logic parity_err_q, parity_err_d;
    logic par_bad;

    always_ff @(posedge clk) begin
        if ((state_q == PARITY) && (bc_q == BC_LAST)) par_bit_q <= rx_s_q;
    end

    // Total ones across data and parity bit must be odd for odd parity, even otherwise.
    assign par_bad = (^{shift_q, par_bit_q}) != PARITY_ODD;

    always_comb begin
        parity_err_d = parity_err_q;
        if (clear_err) parity_err_d = 1'b0;
        if (good_frame && par_bad) parity_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif

    always_comb begin
        rx_total_d  = rx_total_q;
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        if (good_frame) rx_total_d = rx_total_q + 32'd1;
        if (clear_err) begin
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
        if (ferr_evt) frame_err_d = 1'b1;
        if (ovf_evt)  overflow_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_total_q  <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rx_total_q  <= rx_total_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (good_frame),
        .wr_data_i (8'(shift_q)),
        .pop_i     (pop),
        .rd_data_o (rd_if.rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (count)
    );

    assign rd_if.rd_valid = !fifo_empty;
    assign rx_total       = rx_total_q;
    assign frame_err      = frame_err_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_capture_monitor.sv
// Directed bench for uart_capture_monitor: 50 MHz clock, 10 Mbaud (5 clk/bit),
// 8 data bits, 4-entry FIFO. Parity checks build when UART_CAPTURE_PARITY_EN is defined.
module tb_uart_capture_monitor;
    import uart_capture_pkg::*;

    localparam int CPB = 5;
`ifdef UART_CAPTURE_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic        clear_err;
    logic [2:0]  count;
    logic [31:0] rx_total;
    logic        frame_err;
    logic        overflow;
`ifdef UART_CAPTURE_PARITY_EN
    logic        parity_err;
    logic        force_par_bad = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    uart_capture_monitor_if rif ();

    uart_capture_monitor #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (10_000_000),
        .DATA_BITS  (8),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .rd_if      (rif),
        .count      (count),
        .rx_total   (rx_total),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clear_err  (clear_err)
`ifdef UART_CAPTURE_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        clear_err = 1'b0;
        rif.rd_ready = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        cycles(CPB);
    endtask

    // Start bit, 8 data bits LSB first, optional even parity, stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_CAPTURE_PARITY_EN
        send_bit((^b) ^ force_par_bad);
`endif
        send_bit(stop_b);
        serial_in = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, 32'(rif.rd_valid), 32'd1);
        check_eq(tag, 32'(rif.rd_data), 32'(exp));
        rif.rd_ready = 1'b1;
        cycles(1);
        rif.rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        clear_err = 1'b0;
        rif.rd_ready = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_valid", 32'(rif.rd_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_total", rx_total, 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);

        // 1: back-to-back 0x41, 0x0A
        send_frame(8'h41, 1'b1);
        send_frame(8'h0A, 1'b1);
        cycles(2);
        check_eq("t1_count", 32'(count), 32'd2);
        pop_check("t1_b0", 8'h41);
        pop_check("t1_b1", 8'h0A);
        check_eq("t1_total", rx_total, 32'd2);
        check_eq("t1_empty", 32'(rif.rd_valid), 32'd0);

        // 2: one-clock glitch on idle line
        do_reset();
        serial_in = 1'b0;
        cycles(1);
        serial_in = 1'b1;
        cycles(5);
        check_eq("t2_idle", 32'(dut.state_q), 32'(IDLE));
        cycles(10);
        check_eq("t2_count", 32'(count), 32'd0);
        check_eq("t2_ferr", 32'(frame_err), 32'd0);
        send_frame(8'h5A, 1'b1);
        cycles(2);
        pop_check("t2_after", 8'h5A);

        // 3: stop bit low, clear, then clear colliding with a new error
        do_reset();
        send_frame(8'h55, 1'b0);
        cycles(10);
        check_eq("t3_ferr", 32'(frame_err), 32'd1);
        check_eq("t3_count", 32'(count), 32'd0);
        check_eq("t3_total", rx_total, 32'd0);
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        check_eq("t3_clr", 32'(frame_err), 32'd0);
        fork
            send_frame(8'h55, 1'b0);
            begin
                repeat (FRAME_CYC - 1) @(posedge clk);
                #1 clear_err = 1'b1;
                @(posedge clk);
                #1 clear_err = 1'b0;
            end
        join
        cycles(10);
        check_eq("t3_evt_wins", 32'(frame_err), 32'd1);

        // 4: overflow with 5 frames, no reads
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        cycles(2);
        check_eq("t4_count", 32'(count), 32'd4);
        check_eq("t4_ovf", 32'(overflow), 32'd1);
        check_eq("t4_total", rx_total, 32'd5);
        for (int i = 1; i <= 4; i++) pop_check("t4_drain", 8'(i));
        check_eq("t4_empty", 32'(count), 32'd0);

        // 5: full FIFO, commit coincides with pop
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        cycles(1);
        check_eq("t5_full", 32'(count), 32'd4);
        check_eq("t5_head", 32'(rif.rd_data), 32'h11);
        fork
            send_frame(8'h15, 1'b1);
            begin
                repeat (FRAME_CYC - 1) @(posedge clk);
                #1 rif.rd_ready = 1'b1;
                @(posedge clk);
                #1 rif.rd_ready = 1'b0;
            end
        join
        check_eq("t5_count", 32'(count), 32'd4);
        check_eq("t5_ovf", 32'(overflow), 32'd0);
        check_eq("t5_total", rx_total, 32'd5);
        pop_check("t5_d0", 8'h12);
        pop_check("t5_d1", 8'h13);
        pop_check("t5_d2", 8'h14);
        pop_check("t5_tail", 8'h15);

        // 6: parity error (feature build) and reset mid-DATA
        do_reset();
`ifdef UART_CAPTURE_PARITY_EN
        force_par_bad = 1'b1;
        send_frame(8'h03, 1'b1);
        force_par_bad = 1'b0;
        cycles(2);
        check_eq("t6_perr", 32'(parity_err), 32'd1);
`else
        send_frame(8'h03, 1'b1);
        cycles(2);
`endif
        check_eq("t6_count", 32'(count), 32'd1);
        check_eq("t6_byte", 32'(rif.rd_data), 32'h03);
        send_frame(8'hC3, 1'b0);
        cycles(10);
        check_eq("t6_ferr", 32'(frame_err), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        serial_in = 1'b1;
        cycles(1);
        check_eq("t6_rst_valid", 32'(rif.rd_valid), 32'd0);
        check_eq("t6_rst_count", 32'(count), 32'd0);
        check_eq("t6_rst_total", rx_total, 32'd0);
        check_eq("t6_rst_ferr", 32'(frame_err), 32'd0);
        check_eq("t6_rst_ovf", 32'(overflow), 32'd0);
`ifdef UART_CAPTURE_PARITY_EN
        check_eq("t6_rst_perr", 32'(parity_err), 32'd0);
`endif
        rst = 1'b0;
        cycles(FRAME_CYC + 10);
        check_eq("t6_no_partial", 32'(count), 32'd0);
        check_eq("t6_idle", 32'(dut.state_q), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
